// File: rtl/mac_load_controller.sv
// mac_load_controller
// Sequences an operand stream into NLANES input registers. Each accepted
// operand is broadcast on lane_din with a one-hot lane_wen one cycle later.
// After the last lane, the block pulses mac_en for MAC_LAT cycles and then
// holds res_valid until the consumer takes the result.
//
// Optional feature macro: SMAC_CTRL_PERF_EN adds the 16-bit perf_jobs
// output, which counts completed result handshakes and wraps at 0xFFFF.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting operands, one lane per transfer
// COMMIT  | final lane_wen on the bus, no further operands accepted
// COMPUTE | mac_en high, down-counter running
// DONE    | res_valid high until res_ready
module mac_load_controller #(
    parameter int RP      = 16,
    parameter int NLANES  = 4,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RP-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NLANES-1:0] lane_wen,
    output logic [RP-1:0]     lane_din,
    output logic              mac_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
`ifdef SMAC_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_jobs
`endif
);

    localparam int PW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int CW = $clog2(MAC_LAT + 1);

    localparam logic [PW-1:0]     LAST_LANE = PW'(NLANES - 1);
    localparam logic [CW-1:0]     LAT_LOAD  = CW'(MAC_LAT);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [NLANES-1:0] LANE0     = NLANES'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMMIT  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;

    // in_ready and busy depend on state only, so the stream can handshake
    // in the first LOAD cycle.
    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    // Job sequencer: state, lane pointer, compute counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            lane_wen  <= '0;
            lane_din  <= '0;
            mac_en    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            lane_wen <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        lane_wen <= LANE0 << ptr;
                        lane_din <= in_data;
                        // The pointer parks on the last lane rather than
                        // wrapping; it is cleared again on the next LOAD entry.
                        if (ptr == LAST_LANE) begin
                            state <= COMMIT;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state  <= COMPUTE;
                    mac_en <= 1'b1;
                    cnt    <= LAT_LOAD;
                end
                COMPUTE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE) begin
                        state     <= DONE;
                        mac_en    <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            state <= LOAD;
                            ptr   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ptr       <= '0;
                    cnt       <= '0;
                    mac_en    <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SMAC_CTRL_PERF_EN
    // Completed-job counter, advanced on each result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs <= 16'h0000;
        end else if (state == DONE && res_ready) begin
            perf_jobs <= perf_jobs + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mac_load_controller.sv
// Scoreboard bench for mac_load_controller (RP=16, NLANES=4, MAC_LAT=3).
// Stimulus tasks push expected lane writes, mac_en cycles and result
// handshakes into queues; a negedge monitor pops and compares them.
module tb_mac_load_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  lane_wen;
    logic [15:0] lane_din;
    logic        mac_en;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
`ifdef SMAC_CTRL_PERF_EN
    logic [15:0] perf_jobs;
`endif

    mac_load_controller #(.RP(16), .NLANES(4), .MAC_LAT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lane_wen (lane_wen),
        .lane_din (lane_din),
        .mac_en   (mac_en),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .busy     (busy)
`ifdef SMAC_CTRL_PERF_EN
        ,
        .perf_jobs(perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [3:0]  wen;
        logic [15:0] din;
    } wev_t;

    wev_t wq[$];
    int   mq[$];
    int   hq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (lane_wen !== 4'b0000) begin
                if (wq.size() == 0) begin
                    chk("wen_unexpected", {28'd0, lane_wen}, 32'd0);
                end else begin
                    wev_t e;
                    e = wq.pop_front();
                    chk("wen_cycle", cyc, e.c);
                    chk("wen_value", {28'd0, lane_wen}, {28'd0, e.wen});
                    chk("din_value", {16'd0, lane_din}, {16'd0, e.din});
                end
            end
            if (mac_en !== 1'b0) begin
                if (mq.size() == 0) chk("mac_unexpected", {31'd0, mac_en}, 32'd0);
                else chk("mac_cycle", cyc, mq.pop_front());
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (hq.size() == 0) chk("hs_unexpected", {31'd0, res_valid}, 32'd0);
                else chk("hs_cycle", cyc, hq.pop_front());
            end
        end
    end

    // One job, entered in its cycle 0 (the cycle start is driven).
    // gap_start/gap_len: LOAD cycles with in_valid=0; hold: cycles of
    // res_ready=0 in DONE; chain: start with the handshake; pulse: stray
    // start/in_valid in LOAD and COMPUTE.
    task automatic run_job(input logic [15:0] base, input int gap_start, input int gap_len,
                           input int hold, input bit chain, input bit pulse);
        int t0;
        int c;
        int lane;
        t0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        res_ready = 1'b0;
        c = 1;
        lane = 0;
        while (lane < 4) begin
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            chk("busy_load", {31'd0, busy}, 32'd1);
            start = pulse && (c == 2);
            if (c >= gap_start && c < gap_start + gap_len) begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                if (c > gap_start) chk("din_hold", {16'd0, lane_din},
                                       {16'd0, 16'(base * (lane))});
            end else begin
                in_valid = 1'b1;
                in_data  = 16'(base * (lane + 1));
                wq.push_back('{c: t0 + c + 1, wen: 4'(1 << lane), din: 16'(base * (lane + 1))});
                lane++;
            end
            step();
            c++;
        end
        start    = 1'b0;
        in_valid = pulse;
        in_data  = 16'hBEEF;
        chk("in_ready_commit", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 3; k++) mq.push_back(t0 + c + k);
        for (int k = 1; k <= 4; k++) begin
            step();
            start = pulse && (k == 1);
            chk("busy_run", {31'd0, busy}, 32'd1);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        c += 4;
        for (int h = 0; h < hold; h++) begin
            chk("res_valid_hold", {31'd0, res_valid}, 32'd1);
            chk("busy_hold", {31'd0, busy}, 32'd1);
            res_ready = 1'b0;
            step();
            c++;
        end
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        start = chain;
        hq.push_back(t0 + c);
        if (!chain) begin
            step();
            res_ready = 1'b0;
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("res_valid_idle", {31'd0, res_valid}, 32'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_lane_wen"}, {28'd0, lane_wen}, 32'd0);
        chk({tag, "_lane_din"}, {16'd0, lane_din}, 32'd0);
        chk({tag, "_mac_en"}, {31'd0, mac_en}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        #2;
        chk_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // basic job
        run_job(16'h0011, 0, 0, 0, 1'b0, 1'b0);
        step();
        // stream gap in cycles 2-3
        run_job(16'h0101, 2, 2, 0, 1'b0, 1'b0);
        step();
        // backpressure for 5 cycles, then back-to-back job
        run_job(16'h0011, 0, 0, 5, 1'b1, 1'b0);
        run_job(16'h0202, 0, 0, 0, 1'b0, 1'b0);
        step();
        // stray start / in_valid pulses must not disturb timing
        run_job(16'h0303, 0, 0, 1, 1'b0, 1'b1);
        step();

        // mid-job reset after two lanes
        t0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0505;
        wq.push_back('{c: t0 + 2, wen: 4'b0001, din: 16'h0505});
        step();
        in_data = 16'h0A0A;
        wq.push_back('{c: t0 + 3, wen: 4'b0010, din: 16'h0A0A});
        step();
        #5;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        run_job(16'h0707, 0, 0, 0, 1'b0, 1'b0);

`ifdef SMAC_CTRL_PERF_EN
        step();
        run_job(16'h0011, 0, 0, 0, 1'b0, 1'b0);
        step();
        run_job(16'h0022, 0, 0, 0, 1'b0, 1'b0);
        chk("perf_three", {16'd0, perf_jobs}, 32'd3);
        force dut.perf_jobs = 16'hFFFF;
        #1;
        release dut.perf_jobs;
        step();
        chk("perf_preload", {16'd0, perf_jobs}, 32'h0000FFFF);
        run_job(16'h0033, 0, 0, 0, 1'b0, 1'b0);
        chk("perf_wrap", {16'd0, perf_jobs}, 32'd0);
`endif

        repeat (3) step();
        chk("wq_empty", wq.size(), 32'd0);
        chk("mq_empty", mq.size(), 32'd0);
        chk("hq_empty", hq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
